// File: rtl/ibuf_wr_packer.sv
// Packs a 64-bit activation stream into 256-bit ibuf words and writes them to consecutive
// ibuf addresses; one transfer per cfg_start, finishing with a one-cycle done pulse.
module ibuf_wr_packer #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned MEM_W  = 256,
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W:0]   cfg_num_words,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              mem_write_req,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [MEM_W-1:0]  mem_write_data,
  output logic              busy,
  output logic              done,
  output logic              err_short
);

  localparam int unsigned BEATS  = MEM_W / DATA_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   base_q;
  logic [ADDR_W:0]     num_q;
  logic [ADDR_W:0]     word_idx_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [MEM_W-1:0]    pack_q;
  logic                last_q;
  logic                err_q;
  logic                req_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [MEM_W-1:0]    data_q;
  logic                done_q;

  logic                accept;
  logic                word_full;
  logic                final_word;
  logic [MEM_W-1:0]    pack_next;
  logic [ADDR_W-1:0]   wr_addr;

  // No new beats once the producer has signalled s_last or every word is already issued.
  assign s_ready    = (state_q == StRun) && !last_q && (word_idx_q < num_q);
  assign accept     = s_valid && s_ready;
  assign word_full  = (beat_q == BEAT_W'(BEATS - 1));
  assign final_word = ((word_idx_q + (ADDR_W + 1)'(1)) == num_q);
  assign wr_addr    = base_q + word_idx_q[ADDR_W-1:0];

  always_comb begin
    pack_next = pack_q;
    pack_next[int'(beat_q) * DATA_W +: DATA_W] = s_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      base_q     <= '0;
      num_q      <= '0;
      word_idx_q <= '0;
      beat_q     <= '0;
      pack_q     <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_start) begin
            base_q     <= cfg_base_addr;
            num_q      <= cfg_num_words;
            word_idx_q <= '0;
            beat_q     <= '0;
            pack_q     <= '0;
            last_q     <= 1'b0;
            err_q      <= 1'b0;
            if (cfg_num_words == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (accept) begin
            if (s_last) begin
              last_q <= 1'b1;
              if (!(word_full && final_word)) begin
                err_q <= 1'b1;
              end
            end
            if (word_full) begin
              req_q      <= 1'b1;
              addr_q     <= wr_addr;
              data_q     <= pack_next;
              word_idx_q <= word_idx_q + (ADDR_W + 1)'(1);
              beat_q     <= '0;
              pack_q     <= '0;
            end else begin
              pack_q <= pack_next;
              beat_q <= beat_q + BEAT_W'(1);
              if (s_last) begin
                state_q <= StFlush;
              end
            end
          end else if (last_q || (word_idx_q == num_q)) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StFlush: begin
          // Partial word: lanes never written are still zero from the last clear.
          req_q      <= 1'b1;
          addr_q     <= wr_addr;
          data_q     <= pack_q;
          word_idx_q <= word_idx_q + (ADDR_W + 1)'(1);
          beat_q     <= '0;
          pack_q     <= '0;
          state_q    <= StDone;
          done_q     <= 1'b1;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign mem_write_req  = req_q;
  assign mem_write_addr = addr_q;
  assign mem_write_data = data_q;
  assign busy           = (state_q == StRun) || (state_q == StFlush);
  assign done           = done_q;
  assign err_short      = err_q;

endmodule

// File: tb/tb_ibuf_wr_packer.sv
// Scoreboard bench for ibuf_wr_packer: the beat driver builds expected ibuf words as it
// sends beats, and a write monitor pops and compares them as the DUT issues writes.
module tb_ibuf_wr_packer;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_start;
  logic [13:0]   cfg_base_addr;
  logic [14:0]   cfg_num_words;
  logic          s_valid;
  logic [63:0]   s_data;
  logic          s_last;
  logic          s_ready;
  logic          mem_write_req;
  logic [13:0]   mem_write_addr;
  logic [255:0]  mem_write_data;
  logic          busy;
  logic          done;
  logic          err_short;

  ibuf_wr_packer #(.DATA_W(64), .MEM_W(256), .ADDR_W(14)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_start      (cfg_start),
    .cfg_base_addr  (cfg_base_addr),
    .cfg_num_words  (cfg_num_words),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_last         (s_last),
    .s_ready        (s_ready),
    .mem_write_req  (mem_write_req),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .busy           (busy),
    .done           (done),
    .err_short      (err_short)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [13:0]  a;
    logic [255:0] d;
  } exp_t;

  exp_t          exp_q[$];
  logic [255:0]  wr_log[$];
  int            wr_cyc[$];
  logic [63:0]   bv[256];
  int            passed = 0;
  int            total = 0;
  int            cyc = 0;
  int            wr_count = 0;
  int            done_count = 0;
  int            done_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every ibuf write must match the oldest expected word.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (mem_write_req) begin
        wr_count++;
        wr_cyc.push_back(cyc);
        wr_log.push_back(mem_write_data);
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_write addr=%h data=%h", mem_write_addr, mem_write_data);
        end else begin
          e = exp_q.pop_front();
          if (mem_write_addr !== e.a || mem_write_data !== e.d)
            $display("FAIL write addr=%h data=%h required addr=%h data=%h",
                     mem_write_addr, mem_write_data, e.a, e.d);
          else passed++;
        end
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic start(input logic [13:0] base, input logic [14:0] num);
    cfg_base_addr = base;
    cfg_num_words = num;
    cfg_start     = 1'b1;
  endtask

  // Sends nbeats from bv[first..], s_last on beat last_idx (-1: none); pushes expected words.
  task automatic drive(input logic [13:0] base, input int nbeats, input int last_idx,
                       input bit gaps, input int first);
    logic [255:0] word;
    int           lane;
    int           widx;
    int           budget;
    bit           acc;
    word = '0;
    lane = 0;
    widx = 0;
    for (int i = 0; i < nbeats; i++) begin
      s_data = bv[first + i];
      s_last = (i == last_idx);
      acc    = 1'b0;
      budget = 0;
      while (!acc) begin
        s_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
        @(negedge clk);
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        budget++;
        if (!acc && budget > 200) begin
          total++;
          $display("FAIL beat_accept_timeout beat=%0d accepted=0 required=1", i);
          s_valid = 1'b0;
          s_last  = 1'b0;
          return;
        end
      end
      word[lane*64 +: 64] = bv[first + i];
      lane++;
      if (lane == 4 || i == last_idx) begin
        exp_q.push_back({base + widx[13:0], word});
        widx++;
        word = '0;
        lane = 0;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string name);
    int n;
    n = 0;
    while (done_count == prev && n < 300) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    total++;
    if (done_count != prev + 1)
      $display("FAIL %s_done_pulses got=%0d required=1", name, done_count - prev);
    else passed++;
    total++;
    if (exp_q.size() != 0)
      $display("FAIL %s_missing_writes got=%0d pending required=0", name, exp_q.size());
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({mem_write_req, done, busy, s_ready, err_short} !== 5'b0)
      $display("FAIL reset_flags got=%b required=00000",
               {mem_write_req, done, busy, s_ready, err_short});
    else passed++;
    total++;
    if (mem_write_addr !== 14'h0 || mem_write_data !== 256'h0)
      $display("FAIL reset_addr_data addr=%h data=%h required 0", mem_write_addr, mem_write_data);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int s0;
    int prev;
    for (int i = 0; i < 8; i++) bv[i] = {8{8'(8'h11 * (i + 1))}};
    wr_cyc.delete();
    prev = done_count;
    start(14'h0010, 15'd2);
    s0 = cyc;
    drive(14'h0010, 8, -1, 1'b0, 0);
    wait_done(prev, "basic");
    total++;
    if (wr_cyc.size() != 2 || wr_cyc[0] - s0 != 5 || wr_cyc[1] - s0 != 9)
      $display("FAIL basic_write_latency writes=%0d required 2 at cycles 5,9", wr_cyc.size());
    else passed++;
    total++;
    if (done_cyc - s0 != 10)
      $display("FAIL basic_done_cycle got=%0d required=10", done_cyc - s0);
    else passed++;
  endtask

  task automatic test_addr_wrap();
    int prev;
    for (int i = 0; i < 12; i++) bv[16 + i] = {$urandom, $urandom};
    prev = done_count;
    start(14'h3FFF, 15'd3);
    drive(14'h3FFF, 12, 11, 1'b0, 16);
    wait_done(prev, "wrap");
    total++;
    if (err_short !== 1'b0) $display("FAIL wrap_err_short got=%b required=0", err_short);
    else passed++;
  endtask

  task automatic test_short();
    int prev;
    int pw;
    bit rdy_seen;
    for (int i = 0; i < 6; i++) bv[32 + i] = {$urandom, $urandom};
    prev = done_count;
    pw   = wr_count;
    start(14'h0100, 15'd2);
    drive(14'h0100, 6, 5, 1'b0, 32);
    rdy_seen = 1'b0;
    s_valid  = 1'b1;
    s_data   = 64'hDEAD_BEEF_0BAD_F00D;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (s_ready) rdy_seen = 1'b1;
    end
    s_valid = 1'b0;
    total++;
    if (rdy_seen) $display("FAIL short_ready_after_last got=1 required=0");
    else passed++;
    wait_done(prev, "short");
    total++;
    if (err_short !== 1'b1) $display("FAIL short_err_short got=%b required=1", err_short);
    else passed++;
    total++;
    if (wr_count - pw != 2) $display("FAIL short_write_count got=%0d required=2", wr_count - pw);
    else passed++;
  endtask

  task automatic test_zero_words();
    int s0;
    int prev;
    int pw;
    bit rdy_seen;
    prev = done_count;
    pw   = wr_count;
    start(14'h0040, 15'd0);
    s_valid = 1'b1;
    s0 = cyc;
    rdy_seen = 1'b0;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (s_ready) rdy_seen = 1'b1;
    end
    s_valid = 1'b0;
    total++;
    if (done_count != prev + 1 || done_cyc - s0 != 1)
      $display("FAIL zero_done pulses=%0d cycle=%0d required 1 at cycle 1",
               done_count - prev, done_cyc - s0);
    else passed++;
    total++;
    if (rdy_seen || wr_count != pw)
      $display("FAIL zero_activity ready=%b writes=%0d required 0,0", rdy_seen, wr_count - pw);
    else passed++;
    total++;
    if (err_short !== 1'b0) $display("FAIL zero_err_cleared got=%b required=0", err_short);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back_gaps();
    int prev;
    int n0;
    logic [255:0] ref_words[$];
    for (int i = 0; i < 64; i++) bv[64 + i] = {$urandom, $urandom};
    prev = done_count;
    n0 = wr_log.size();
    start(14'h1230, 15'd16);
    drive(14'h1230, 64, -1, 1'b0, 64);
    wait_done(prev, "nogap");
    for (int i = n0; i < wr_log.size(); i++) ref_words.push_back(wr_log[i]);
    prev = done_count;
    n0 = wr_log.size();
    start(14'h1230, 15'd16);
    drive(14'h1230, 64, -1, 1'b1, 64);
    wait_done(prev, "gaps");
    total++;
    if (ref_words.size() != 16 || wr_log.size() - n0 != 16)
      $display("FAIL gaps_count got=%0d,%0d required=16,16", ref_words.size(), wr_log.size() - n0);
    else begin
      bit same;
      same = 1'b1;
      for (int i = 0; i < 16; i++) if (wr_log[n0 + i] !== ref_words[i]) same = 1'b0;
      if (!same) $display("FAIL gaps_vs_nogap got=differ required=identical");
      else passed++;
    end
  endtask

  task automatic test_reset_abort();
    int prev;
    int pw;
    for (int i = 0; i < 13; i++) bv[160 + i] = {$urandom, $urandom};
    prev = done_count;
    start(14'h0200, 15'd4);
    drive(14'h0200, 9, -1, 1'b0, 160);
    reset = 1'b0;
    pw = wr_count;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || s_ready !== 1'b0 || mem_write_req !== 1'b0)
      $display("FAIL abort_idle busy=%b ready=%b req=%b required 0,0,0",
               busy, s_ready, mem_write_req);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (6) @(negedge clk);
    total++;
    if (wr_count != pw || done_count != prev || exp_q.size() != 0)
      $display("FAIL abort_no_activity writes=%0d dones=%0d pending=%0d required 0,0,0",
               wr_count - pw, done_count - prev, exp_q.size());
    else passed++;
    @(posedge clk);
    #1;
    prev = done_count;
    pw   = wr_count;
    start(14'h0300, 15'd1);
    drive(14'h0300, 4, -1, 1'b0, 169);
    wait_done(prev, "restart");
    total++;
    if (wr_count - pw != 1 || err_short !== 1'b0)
      $display("FAIL restart writes=%0d err=%b required 1,0", wr_count - pw, err_short);
    else passed++;
  endtask

  initial begin
    reset         = 1'b0;
    cfg_start     = 1'b0;
    cfg_base_addr = '0;
    cfg_num_words = '0;
    s_valid       = 1'b0;
    s_data        = '0;
    s_last        = 1'b0;
    test_reset();
    test_basic();
    test_addr_wrap();
    test_short();
    test_zero_words();
    test_back_to_back_gaps();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
